// File: rtl/stream_rr_arb_if.sv
// Handshake bundle for stream_rr_arb: N_REQ requester lanes in, one
// registered stream out. The "slave" modport is the arbiter's view and the
// "master" modport is the view of whatever drives requests and takes beats.
interface stream_rr_arb_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ-1:0]       req_rdy;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic [SRC_W-1:0]       out_src;
  logic                   out_vld;
  logic                   out_rdy;

  modport master (
    output req_data, req_last, req_vld, out_rdy,
    input  req_rdy, out_data, out_last, out_src, out_vld
  );

  modport slave (
    input  req_data, req_last, req_vld, out_rdy,
    output req_rdy, out_data, out_last, out_src, out_vld
  );
endinterface

// File: rtl/stream_rr_arb.sv
// stream_rr_arb: N_REQ-way round-robin arbiter feeding one registered
// valid/ready stage. Once a requester wins with a non-last beat it owns the
// output until its last beat, so packets never interleave.
// Optional feature: define STREAM_RR_ARB_CNT_EN to add the saturating 16-bit
// pkt_cnt output counting accepted last beats.
module stream_rr_arb #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef STREAM_RR_ARB_CNT_EN
  output logic [15:0] pkt_cnt,
`endif
  stream_rr_arb_if.slave bus
);
  localparam int SRC_W = $clog2(N_REQ);

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_nxt;
  logic [SRC_W-1:0] owner, owner_nxt;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] sel;
  logic             any_vld;
  logic             load;
  logic             take;
  logic [N_REQ-1:0] rdy;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  logic [WIDTH-1:0] data_p1;
  logic             last_p1;
  logic [SRC_W-1:0] src_p1;
  logic             vld_p1;

  // Round-robin successor; explicit wrap keeps non-power-of-2 N_REQ correct.
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] i);
    if (i == SRC_W'(N_REQ - 1)) begin
      return '0;
    end else begin
      return i + 1'b1;
    end
  endfunction

`ifdef STREAM_RR_ARB_CNT_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction
`endif

  // Stage can take a new beat when empty or when its current beat leaves.
  assign load = bus.out_rdy | ~vld_p1;

  // Find the first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    any_vld = 1'b0;
    grant   = rr_ptr;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any_vld && bus.req_vld[idx]) begin
        any_vld = 1'b1;
        grant   = SRC_W'(idx);
      end
    end
  end

  // FSM state, round-robin pointer and packet owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      owner  <= owner_nxt;
    end
  end

  // Next-state, grant and per-requester ready decisions.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    rdy       = '0;
    take      = 1'b0;
    sel       = grant;
    case (state)
      IDLE: begin
        sel = grant;
        if (load && any_vld) begin
          rdy[grant] = 1'b1;
          take       = 1'b1;
          if (bus.req_last[grant]) begin
            rr_nxt = next_idx(grant);
          end else begin
            state_nxt = LOCKED;
            owner_nxt = grant;
          end
        end
      end
      LOCKED: begin
        sel        = owner;
        rdy[owner] = load;
        if (load && bus.req_vld[owner]) begin
          take = 1'b1;
          if (bus.req_last[owner]) begin
            state_nxt = IDLE;
            rr_nxt    = next_idx(owner);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Nothing is accepted while reset is held.
  assign bus.req_rdy = rst ? '0 : rdy;

  // Mux the selected requester's beat toward the output register.
  always_comb begin
    sel_data = bus.req_data[int'(sel)*WIDTH +: WIDTH];
    sel_last = bus.req_last[sel];
  end

  // ---- stage p1: output register, loads only when the stage may advance ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= '0;
    end else if (load) begin
      vld_p1 <= take;
      if (take) begin
        data_p1 <= sel_data;
        last_p1 <= sel_last;
        src_p1  <= sel;
      end
    end
  end

  assign bus.out_data = data_p1;
  assign bus.out_last = last_p1;
  assign bus.out_src  = src_p1;
  assign bus.out_vld  = vld_p1;

`ifdef STREAM_RR_ARB_CNT_EN
  // Count completed packets as their last beat enters the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (take && sel_last) begin
      pkt_cnt <= sat_inc(pkt_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed bench for stream_rr_arb: a 4-requester instance for the main
// arbitration/packet/stall/reset scenarios and a 3-requester instance for
// non-power-of-2 wrap.
module tb_stream_rr_arb;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  stream_rr_arb_if #(.WIDTH(32), .N_REQ(4)) b4 ();
  stream_rr_arb_if #(.WIDTH(32), .N_REQ(3)) b3 ();

`ifdef STREAM_RR_ARB_CNT_EN
  logic [15:0] cnt4;
  logic [15:0] cnt3;
`endif

  stream_rr_arb #(.WIDTH(32), .N_REQ(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
`ifdef STREAM_RR_ARB_CNT_EN
    .pkt_cnt (cnt4),
`endif
    .bus     (b4.slave)
  );

  stream_rr_arb #(.WIDTH(32), .N_REQ(3)) dut3 (
    .clk     (clk),
    .rst     (rst),
`ifdef STREAM_RR_ARB_CNT_EN
    .pkt_cnt (cnt3),
`endif
    .bus     (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [31:0] d);
    b4.req_vld[i]          = v;
    b4.req_last[i]         = l;
    b4.req_data[i*32 +: 32] = d;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] src, input logic [31:0] data,
                         input logic last);
    check({tag, "_vld"},  32'(b4.out_vld),  32'd1);
    check({tag, "_src"},  32'(b4.out_src),  32'(src));
    check({tag, "_data"}, b4.out_data,      data);
    check({tag, "_last"}, 32'(b4.out_last), 32'(last));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    b4.req_data = '0;
    b4.req_last = '0;
    b4.req_vld  = 4'hF;
    b4.out_rdy  = 1'b0;
    b3.req_data = '0;
    b3.req_last = '0;
    b3.req_vld  = '0;
    b3.out_rdy  = 1'b1;

    // Reset state; requests pending but nothing may be accepted
    #3;
    check("rst_vld",  32'(b4.out_vld),  32'd0);
    check("rst_data", b4.out_data,      32'd0);
    check("rst_src",  32'(b4.out_src),  32'd0);
    check("rst_last", 32'(b4.out_last), 32'd0);
    check("rst_rdy",  32'(b4.req_rdy),  32'd0);
    check("rst_vld3", 32'(b3.out_vld),  32'd0);
    tick();
    tick();
    rst = 1'b0;
    b4.req_vld = '0;

    // Round robin over four single-beat requesters, back to back
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 32'h100 + 32'(i));
    b4.out_rdy = 1'b1;
    settle();
    check("rr_rdy_first", 32'(b4.req_rdy), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("rr", 2'(k % 4), 32'h100 + 32'(k % 4), 1'b1);
      check("rr_rdy", 32'(b4.req_rdy), 32'(1 << ((k + 1) % 4)));
    end
    b4.req_vld = '0;
    tick();
    check("rr_bubble", 32'(b4.out_vld), 32'd0);

    // rr_ptr is now 1: req1 sends a 3-beat packet with one gap, req2 waits
    set_req(1, 1'b1, 1'b0, 32'h210);
    set_req(2, 1'b1, 1'b1, 32'h320);
    settle();
    check("pk_rdy0", 32'(b4.req_rdy), 32'b0010);
    tick();
    chk_out("pk_b0", 2'd1, 32'h210, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h211);
    settle();
    check("pk_rdy1", 32'(b4.req_rdy), 32'b0010);
    tick();
    chk_out("pk_b1", 2'd1, 32'h211, 1'b0);
    set_req(1, 1'b0, 1'b0, 32'h211);
    settle();
    check("pk_gap_rdy", 32'(b4.req_rdy), 32'b0010);
    tick();
    check("pk_gap_vld", 32'(b4.out_vld), 32'd0);
    set_req(1, 1'b1, 1'b1, 32'h212);
    settle();
    check("pk_rdy2", 32'(b4.req_rdy), 32'b0010);
    tick();
    chk_out("pk_b2", 2'd1, 32'h212, 1'b1);
    set_req(1, 1'b0, 1'b0, 32'h0);
    settle();
    check("pk_rdy_next", 32'(b4.req_rdy), 32'b0100);
    tick();
    chk_out("pk_next", 2'd2, 32'h320, 1'b1);
    set_req(2, 1'b0, 1'b0, 32'h0);

    // rr_ptr is now 3: downstream stall for five cycles
    set_req(0, 1'b1, 1'b1, 32'h400);
    set_req(3, 1'b1, 1'b1, 32'h430);
    settle();
    check("st_rdy0", 32'(b4.req_rdy), 32'b1000);
    tick();
    chk_out("st_b0", 2'd3, 32'h430, 1'b1);
    set_req(3, 1'b0, 1'b0, 32'h0);
    b4.out_rdy = 1'b0;
    settle();
    check("st_rdy_hold", 32'(b4.req_rdy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("st_hold", 2'd3, 32'h430, 1'b1);
      check("st_hold_rdy", 32'(b4.req_rdy), 32'd0);
    end
    b4.out_rdy = 1'b1;
    settle();
    check("st_rdy_go", 32'(b4.req_rdy), 32'b0001);
    tick();
    chk_out("st_b1", 2'd0, 32'h400, 1'b1);
    set_req(0, 1'b0, 1'b0, 32'h0);
    tick();
    check("st_drain", 32'(b4.out_vld), 32'd0);

    // Reset in the middle of a 4-beat packet from req3
    set_req(3, 1'b1, 1'b0, 32'h500);
    settle();
    check("rp_rdy0", 32'(b4.req_rdy), 32'b1000);
    tick();
    chk_out("rp_b0", 2'd3, 32'h500, 1'b0);
    set_req(3, 1'b1, 1'b0, 32'h501);
    tick();
    chk_out("rp_b1", 2'd3, 32'h501, 1'b0);
    rst = 1'b1;
    settle();
    check("rp_vld",  32'(b4.out_vld),  32'd0);
    check("rp_data", b4.out_data,      32'd0);
    check("rp_src",  32'(b4.out_src),  32'd0);
    check("rp_last", 32'(b4.out_last), 32'd0);
    check("rp_rdy",  32'(b4.req_rdy),  32'd0);
    tick();
    check("rp_vld_held", 32'(b4.out_vld), 32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h600);
    set_req(3, 1'b1, 1'b0, 32'h502);
    settle();
    check("rp_rdy_after", 32'(b4.req_rdy), 32'b0001);
    tick();
    chk_out("rp_req0", 2'd0, 32'h600, 1'b1);
    set_req(0, 1'b0, 1'b0, 32'h0);
    settle();
    check("rp_rdy_req3", 32'(b4.req_rdy), 32'b1000);
    tick();
    chk_out("rp_req3", 2'd3, 32'h502, 1'b0);
    set_req(3, 1'b1, 1'b1, 32'h503);
    tick();
    chk_out("rp_req3_end", 2'd3, 32'h503, 1'b1);
    set_req(3, 1'b0, 1'b0, 32'h0);
    tick();

`ifdef STREAM_RR_ARB_CNT_EN
    // Two packets completed since reset; eight more reach ten
    check("cnt_2", 32'(cnt4), 32'd2);
    set_req(0, 1'b1, 1'b1, 32'h700);
    for (int k = 0; k < 8; k++) tick();
    set_req(0, 1'b0, 1'b0, 32'h0);
    tick();
    check("cnt_10", 32'(cnt4), 32'd10);
    set_req(0, 1'b1, 1'b1, 32'h701);
    for (int k = 0; k < 65530; k++) tick();
    set_req(0, 1'b0, 1'b0, 32'h0);
    tick();
    check("cnt_sat", 32'(cnt4), 32'hFFFF);
`endif

    // Three requesters: pointer wraps 2 -> 0
    for (int i = 0; i < 3; i++) begin
      b3.req_vld[i]           = 1'b1;
      b3.req_last[i]          = 1'b1;
      b3.req_data[i*32 +: 32] = 32'h800 + 32'(i);
    end
    settle();
    check("n3_rdy_first", 32'(b3.req_rdy), 32'b001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("n3_vld",  32'(b3.out_vld), 32'd1);
      check("n3_src",  32'(b3.out_src), 32'(k % 3));
      check("n3_data", b3.out_data,     32'h800 + 32'(k % 3));
      check("n3_rdy",  32'(b3.req_rdy), 32'(1 << ((k + 1) % 3)));
    end
    b3.req_vld = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
